inv_mix_columns_iter: RTL and testbench
=======================================

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: in_state holds a valid 128-bit AES state.
REQ-004 The block SHALL have port in_ready, output, 1 bit: the block can accept a state this cycle.
REQ-005 The block SHALL have port in_state, input, 128 bits: column c in bits [127-32c -: 32], row 0 the MSB byte of each column.
REQ-006 The block SHALL have port out_valid, output, 1 bit: out_state holds a finished result.
REQ-007 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_state.
REQ-008 The block SHALL have port out_state, output, 128 bits: the transformed state, same column and byte layout as in_state.

Function
REQ-009 The block SHALL compute the AES InvMixColumns: each column is multiplied by {0e,0b,0d,09} (circulant) over GF(2^8), with reduction polynomial 0x11B.
REQ-010 The block SHALL use a single 32-bit column datapath, time-shared and iterated over the 4 columns.
REQ-011 The block SHALL use FSM states IDLE, BUSY and DONE.
REQ-012 IDLE SHALL drive in_ready=1 and out_valid=0; when in_valid=1, the block SHALL capture in_state into the working register, clear the 2-bit column counter and go to BUSY.
REQ-013 BUSY SHALL drive in_ready=0 and out_valid=0; each cycle it SHALL replace the column selected by the counter with its transformed value and increment the counter.
REQ-014 After the column-3 cycle the counter SHALL wrap 3->0 and the FSM SHALL go to DONE.
REQ-015 Latency SHALL be fixed: acceptance on edge N, 4 BUSY cycles, and out_valid=1 from the cycle after edge N+4.
REQ-016 DONE SHALL drive out_valid=1 and in_ready=0, holding out_state stable until out_ready=1.
REQ-017 On out_ready=1 in DONE, the FSM SHALL return to IDLE; no new state SHALL be accepted in that same cycle, so the minimum issue interval is 6 cycles.
REQ-018 in_valid and in_state SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-019 out_state SHALL equal the working register at all times; its contents are don't-care while out_valid=0.

Reset
REQ-020 With reset=1 at a clock edge, the FSM SHALL go to IDLE, the counter to 0 and the working register to 128'h0, giving in_ready=1, out_valid=0 and out_state=0 from the following cycle.
REQ-021 Reset SHALL take priority over every other event; a reset during BUSY or DONE SHALL discard the operation in progress with no output.
REQ-022 in_valid=1 in the reset cycle SHALL NOT be accepted.

Configuration
REQ-023 With macro MIXCOL_FWD_MODE_EN defined, the block SHALL add input port fwd_mode (1 bit), captured on acceptance.
REQ-024 With fwd_mode=1, the block SHALL apply the forward MixColumns matrix {02,03,01,01} for that operation.
REQ-025 With fwd_mode=0, the block SHALL apply the inverse transform.
REQ-026 Without MIXCOL_FWD_MODE_EN, the fwd_mode port and the forward logic SHALL be absent, and the block SHALL perform the inverse transform only; timing SHALL be identical in both builds.

Verification
REQ-027 Single operation: in_state=046681e5_e0cb199a_48f8d37a_2806264c, out_ready=1 -> out_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5, with out_valid high exactly 5 cycles after acceptance, for 1 cycle.
REQ-028 Backpressure: same stimulus with out_ready=0 for 10 cycles -> out_valid stays high, out_state is unchanged, in_ready=0, and a new in_valid is ignored; raising out_ready -> IDLE on the next cycle.
REQ-029 Identity column: in_state=01010101 in all 4 columns -> out_state=01010101 in all 4 columns; in_state=all zero -> all zero.
REQ-030 Reset mid-operation: assert reset in the 2nd BUSY cycle -> the next cycle has in_ready=1, out_valid=0, out_state=0, and no out_valid pulse appears afterwards.
REQ-031 Back-to-back: two states presented with in_valid held high -> the second is accepted exactly 6 cycles after the first (out_ready=1), and both results are correct.
REQ-032 MIXCOL_FWD_MODE_EN build: fwd_mode=1, in_state=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_state=046681e5_e0cb199a_48f8d37a_2806264c.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
//   Iterative AES InvMixColumns over a 128-bit state. A single 32-bit column
//   datapath is reused for four consecutive cycles, one column per cycle,
//   updating the working register in place.
//
//   Optional build macro: MIXCOL_FWD_MODE_EN
//     When defined, adds input fwd_mode. It is captured when a state is
//     accepted and selects the forward MixColumns matrix for that operation.
//     Cycle timing is the same in both builds.
//
//   Ports
//     clk        : clock, rising edge
//     reset      : synchronous active-high reset
//     in_valid   : in_state carries a state to transform
//     in_ready   : block accepts a state this cycle (IDLE)
//     in_state   : input state, column c in bits [127-32c -: 32], row 0 = MSB
//     out_valid  : out_state holds a finished result (DONE)
//     out_ready  : consumer takes out_state
//     out_state  : working register, same layout as in_state
//     fwd_mode   : (MIXCOL_FWD_MODE_EN only) 1 = forward MixColumns
// ---------------------------------------------------------------------------
module inv_mix_columns_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
`ifdef MIXCOL_FWD_MODE_EN
    ,
    input  logic         fwd_mode
`endif
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned NUM_COL = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // GF(2^8) multiply by x, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Inverse column transform, circulant {0e,0b,0d,09}
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
        r1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
        r2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
        r3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        return {r0, r1, r2, r3};
    endfunction

`ifdef MIXCOL_FWD_MODE_EN
    // Forward column transform, circulant {02,03,01,01}
    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction
`endif

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [1:0]         cnt;
    logic [1:0]         cnt_nxt;
    logic [STATE_W-1:0] work;
    logic [STATE_W-1:0] work_nxt;
    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;

`ifdef MIXCOL_FWD_MODE_EN
    logic               mode;
    logic               mode_nxt;
`endif

    // Column mux: slot j holds column 3-j (column 0 sits in the MSBs)
    always_comb begin
        col_in = '0;
        for (int j = 0; j < int'(NUM_COL); j++) begin
            if (cnt == 2'(3 - j)) begin
                col_in = work[COL_W*j +: COL_W];
            end
        end
    end

    // Shared column datapath
`ifdef MIXCOL_FWD_MODE_EN
    assign col_out = mode ? fwd_col(col_in) : inv_col(col_in);
`else
    assign col_out = inv_col(col_in);
`endif

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
`ifdef MIXCOL_FWD_MODE_EN
        mode_nxt  = mode;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_nxt  = in_state;
                    cnt_nxt   = 2'd0;
                    state_nxt = BUSY;
`ifdef MIXCOL_FWD_MODE_EN
                    mode_nxt  = fwd_mode;
`endif
                end
            end
            BUSY: begin
                for (int j = 0; j < int'(NUM_COL); j++) begin
                    if (cnt == 2'(3 - j)) begin
                        work_nxt[COL_W*j +: COL_W] = col_out;
                    end
                end
                // Counter wraps 3->0 on the last column
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef MIXCOL_FWD_MODE_EN
            mode      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            work      <= work_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
`ifdef MIXCOL_FWD_MODE_EN
            mode      <= mode_nxt;
`endif
        end
    end

    assign out_state = work;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_columns_iter
//   Directed bench for inv_mix_columns_iter. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_inv_mix_columns_iter;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         fwd_mode;

    int passed;
    int total;

    localparam logic [127:0] V_IN   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V_OUT  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] ID_V   = 128'h01010101_01010101_01010101_01010101;
    localparam logic [127:0] HOT_IN = 128'h01000000_00000001_00010000_00000100;
    localparam logic [127:0] HOT_EX = 128'h0e090d0b_090d0b0e_0b0e090d_0d0b0e09;
    localparam logic [127:0] RED_IN = 128'h80000000_00800000_00008000_00000080;
    localparam logic [127:0] RED_EX = 128'h41ecdaf7_f741ecda_daf741ec_ecdaf741;

    inv_mix_columns_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
`ifdef MIXCOL_FWD_MODE_EN
        ,
        .fwd_mode  (fwd_mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One operation with out_ready=1: accept, 4 busy cycles, 1 DONE cycle
    task automatic run_op(input string tag, input logic [127:0] din, input logic [127:0] exp);
        in_valid  = 1'b1;
        in_state  = din;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_state = '0;
        check({tag, "_busy_ready"}, 128'(in_ready), 128'(1'b0));
        tick();
        tick();
        tick();
        check({tag, "_early_valid"}, 128'(out_valid), 128'(1'b0));
        tick();
        check({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, "_data"}, out_state, exp);
        tick();
        check({tag, "_pulse_end"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_idle_ready"}, 128'(in_ready), 128'(1'b1));
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        fwd_mode  = 1'b0;

        // Reset, with in_valid asserted in the reset cycle (must not be taken)
        tick();
        in_valid = 1'b1;
        in_state = V_IN;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_state = '0;
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_state", out_state, '0);

        // Directed single operations
        run_op("main", V_IN, V_OUT);
        run_op("ident", ID_V, ID_V);
        run_op("zero", '0, '0);
        run_op("onehot", HOT_IN, HOT_EX);
        run_op("reduce", RED_IN, RED_EX);

        // Backpressure: hold DONE for 10 cycles while a new state is offered
        in_valid  = 1'b1;
        in_state  = V_IN;
        out_ready = 1'b0;
        tick();
        in_state = HOT_IN;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 128'(out_valid), 128'(1'b1));
            check("bp_ready", 128'(in_ready), 128'(1'b0));
            check("bp_data", out_state, V_OUT);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(out_valid), 128'(1'b0));
        check("bp_release_ready", 128'(in_ready), 128'(1'b1));
        check("bp_release_data", out_state, V_OUT);
        in_valid = 1'b0;
        in_state = '0;
        tick();

        // Reset in the second BUSY cycle discards the operation
        in_valid = 1'b1;
        in_state = V_IN;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 128'(in_ready), 128'(1'b1));
        check("midrst_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_data", out_state, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_pulse", 128'(out_valid), 128'(1'b0));
        end

        // Back-to-back with in_valid held high: second accept 6 cycles later
        in_valid  = 1'b1;
        in_state  = V_IN;
        out_ready = 1'b1;
        tick();
        in_state = HOT_IN;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_a_valid", 128'(out_valid), 128'(1'b1));
        check("b2b_a_data", out_state, V_OUT);
        tick();
        check("b2b_gap_ready", 128'(in_ready), 128'(1'b1));
        check("b2b_gap_valid", 128'(out_valid), 128'(1'b0));
        tick();
        in_valid = 1'b0;
        in_state = '0;
        check("b2b_b_accepted", 128'(in_ready), 128'(1'b0));
        for (int i = 0; i < 3; i++) tick();
        check("b2b_b_early", 128'(out_valid), 128'(1'b0));
        tick();
        check("b2b_b_valid", 128'(out_valid), 128'(1'b1));
        check("b2b_b_data", out_state, HOT_EX);
        tick();
        check("b2b_b_end", 128'(out_valid), 128'(1'b0));

`ifdef MIXCOL_FWD_MODE_EN
        // Forward MixColumns, then inverse again in the same build
        fwd_mode = 1'b1;
        run_op("fwd", V_OUT, V_IN);
        fwd_mode = 1'b0;
        run_op("fwd_off", V_IN, V_OUT);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
